// File: rtl/icache_fetch_if.sv
// rtl/icache_fetch_if.sv - IF-side request/response and mem_ctrl fetch signals of icache_fetch
interface icache_fetch_if;
    logic        flush_i;
    logic        if_req_i;
    logic [31:0] if_pc_i;
    logic [31:0] if_inst_o;
    logic        if_valid_o;
    logic        if_busy_o;
    logic [31:0] mem_pc_o;
    logic        mem_pc_done_i;
    logic [31:0] mem_pc_num_i;
    logic [31:0] mem_inst_i;

    modport slave (
        input  flush_i, if_req_i, if_pc_i, mem_pc_done_i, mem_pc_num_i, mem_inst_i,
        output if_inst_o, if_valid_o, if_busy_o, mem_pc_o
    );

    modport master (
        output flush_i, if_req_i, if_pc_i, mem_pc_done_i, mem_pc_num_i, mem_inst_i,
        input  if_inst_o, if_valid_o, if_busy_o, mem_pc_o
    );
endinterface

// File: rtl/icache_fetch.sv
// rtl/icache_fetch.sv - direct-mapped one-word-line instruction cache in front of mem_ctrl
// Optional hit/miss counters when ICACHE_STAT_EN is defined.
module icache_fetch #(
    parameter int INDEX_BITS = 7,
    parameter int ADDR_BITS  = 17
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy_in,
    icache_fetch_if.slave      bus
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0]        hit_cnt_o,
    output logic [31:0]        miss_cnt_o
`endif
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - 2;

    typedef enum logic {
        IDLE,
        MISS
    } state_t;

    state_t              state_q;
    logic [31:0]         miss_pc_q;
    logic [31:0]         if_inst_q;
    logic [31:0]         mem_pc_q;
    logic                if_valid_q;
    logic                if_busy_q;
    logic [LINES-1:0]    valid_q;
    logic [31:0]         data_q [LINES];
    logic [TAG_BITS-1:0] tag_q  [LINES];

    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_BITS-1:0]   fill_tag;
    logic                  hit;
    logic                  idle_req;
    logic                  fill_match;
    logic                  fill_we;

    assign req_idx    = bus.if_pc_i[INDEX_BITS+1:2];
    assign req_tag    = bus.if_pc_i[ADDR_BITS-1:INDEX_BITS+2];
    assign fill_idx   = miss_pc_q[INDEX_BITS+1:2];
    assign fill_tag   = miss_pc_q[ADDR_BITS-1:INDEX_BITS+2];
    assign hit        = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign idle_req   = (state_q == IDLE) && bus.if_req_i && !bus.flush_i;
    assign fill_match = (state_q == MISS) && bus.mem_pc_done_i
                        && (bus.mem_pc_num_i == miss_pc_q);
    // A matching return is written even when a flush cancels its delivery to IF.
    assign fill_we    = rdy_in && fill_match;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            miss_pc_q  <= '0;
            if_inst_q  <= '0;
            mem_pc_q   <= '0;
            if_valid_q <= 1'b0;
            if_busy_q  <= 1'b0;
        end else if (!rdy_in) begin
            if_valid_q <= 1'b0;
        end else begin
            if_valid_q <= 1'b0;
            if (fill_we) begin
                valid_q[fill_idx] <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (idle_req) begin
                        if (hit) begin
                            if_inst_q  <= data_q[req_idx];
                            if_valid_q <= 1'b1;
                        end else begin
                            miss_pc_q <= bus.if_pc_i & ~32'h3;
                            mem_pc_q  <= bus.if_pc_i & ~32'h3;
                            if_busy_q <= 1'b1;
                            state_q   <= MISS;
                        end
                    end
                end
                MISS: begin
                    if (bus.flush_i) begin
                        if_busy_q <= 1'b0;
                        state_q   <= IDLE;
                    end else if (fill_match) begin
                        if_inst_q  <= bus.mem_inst_i;
                        if_valid_q <= 1'b1;
                        if_busy_q  <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_q[fill_idx] <= bus.mem_inst_i;
            tag_q[fill_idx]  <= fill_tag;
        end
    end

`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (rdy_in && idle_req) begin
            if (hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

    assign bus.if_inst_o  = if_inst_q;
    assign bus.if_valid_o = if_valid_q;
    assign bus.if_busy_o  = if_busy_q;
    assign bus.mem_pc_o   = mem_pc_q;

endmodule

// File: tb/tb_icache_fetch.sv
// tb/tb_icache_fetch.sv - scoreboard bench for icache_fetch
module tb_icache_fetch;
    logic clk = 1'b0;
    logic rst;
    logic rdy_in;
`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    icache_fetch_if bus();

    icache_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .rdy_in     (rdy_in),
        .bus        (bus)
`ifdef ICACHE_STAT_EN
        ,
        .hit_cnt_o  (hit_cnt),
        .miss_cnt_o (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks   = 0;
    int          n_pass     = 0;
    int          n_expected = 0;
    int          n_served   = 0;
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.if_valid_o) begin
            n_served++;
            if (exp_q.size() == 0) check("unexpected_valid", {31'd0, bus.if_valid_o}, 32'd0);
            else check("if_inst", bus.if_inst_o, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_inst(input logic [31:0] inst);
        exp_q.push_back(inst);
        n_expected++;
    endtask

    task automatic req(input logic [31:0] pc);
        bus.if_req_i = 1'b1;
        bus.if_pc_i  = pc;
        tick();
        bus.if_req_i = 1'b0;
    endtask

    task automatic mem_done(input logic [31:0] num, input logic [31:0] inst);
        bus.mem_pc_done_i = 1'b1;
        bus.mem_pc_num_i  = num;
        bus.mem_inst_i    = inst;
        tick();
        bus.mem_pc_done_i = 1'b0;
    endtask

    task automatic wait_served();
        int cyc = 0;
        while (n_served < n_expected && cyc < 50) begin
            tick();
            cyc++;
        end
        tick();
        check("served", n_served, n_expected);
    endtask

    task automatic miss_fill(input logic [31:0] pc, input logic [31:0] inst);
        expect_inst(inst);
        req(pc);
        check("miss_busy", {31'd0, bus.if_busy_o}, 32'd1);
        check("miss_mem_pc", bus.mem_pc_o, pc);
        mem_done(pc, inst);
        check("fill_busy", {31'd0, bus.if_busy_o}, 32'd0);
        wait_served();
    endtask

    initial begin
        rst               = 1'b1;
        rdy_in            = 1'b1;
        bus.flush_i       = 1'b0;
        bus.if_req_i      = 1'b0;
        bus.if_pc_i       = '0;
        bus.mem_pc_done_i = 1'b0;
        bus.mem_pc_num_i  = '0;
        bus.mem_inst_i    = '0;
        #12;
        check("rst_inst",   bus.if_inst_o, 32'd0);
        check("rst_valid",  {31'd0, bus.if_valid_o}, 32'd0);
        check("rst_busy",   {31'd0, bus.if_busy_o}, 32'd0);
        check("rst_mem_pc", bus.mem_pc_o, 32'd0);
        tick();
        rst = 1'b0;

        // 1 cold miss with a 3-cycle memory latency
        expect_inst(32'h0010_0093);
        req(32'h0000_1000);
        check("t1_busy0", {31'd0, bus.if_busy_o}, 32'd1);
        check("t1_mem_pc", bus.mem_pc_o, 32'h0000_1000);
        tick();
        check("t1_busy1", {31'd0, bus.if_busy_o}, 32'd1);
        tick();
        check("t1_busy2", {31'd0, bus.if_busy_o}, 32'd1);
        mem_done(32'h0000_1000, 32'h0010_0093);
        check("t1_busy_done", {31'd0, bus.if_busy_o}, 32'd0);
        wait_served();

        // 2 hit
        expect_inst(32'h0010_0093);
        req(32'h0000_1000);
        check("t2_valid", {31'd0, bus.if_valid_o}, 32'd1);
        check("t2_busy", {31'd0, bus.if_busy_o}, 32'd0);
        check("t2_mem_pc", bus.mem_pc_o, 32'h0000_1000);
        wait_served();

        // 3 stale return, flush, late return
        req(32'h0000_2000);
        check("t3_busy", {31'd0, bus.if_busy_o}, 32'd1);
        mem_done(32'h0000_1FFC, 32'hDEAD_BEEF);
        check("t3_stale_busy", {31'd0, bus.if_busy_o}, 32'd1);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        check("t3_flush_busy", {31'd0, bus.if_busy_o}, 32'd0);
        mem_done(32'h0000_2000, 32'h1234_5678);
        check("t3_late_busy", {31'd0, bus.if_busy_o}, 32'd0);
        req(32'h0000_2000);
        check("t3_not_filled", {31'd0, bus.if_busy_o}, 32'd1);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;

        // flush together with a matching return: line filled, no delivery
        req(32'h0000_3000);
        bus.flush_i       = 1'b1;
        bus.mem_pc_done_i = 1'b1;
        bus.mem_pc_num_i  = 32'h0000_3000;
        bus.mem_inst_i    = 32'hCAFE_0001;
        tick();
        bus.flush_i       = 1'b0;
        bus.mem_pc_done_i = 1'b0;
        check("flushfill_busy", {31'd0, bus.if_busy_o}, 32'd0);
        tick();
        expect_inst(32'hCAFE_0001);
        req(32'h0000_3000);
        check("flushfill_hit", {31'd0, bus.if_busy_o}, 32'd0);
        wait_served();

        // 4 aliasing lines at the same index
        miss_fill(32'h0000_0004, 32'hAAAA_0004);
        miss_fill(32'h0000_0204, 32'hBBBB_0204);
        miss_fill(32'h0000_0004, 32'hAAAA_0004);
        miss_fill(32'h0000_0204, 32'hBBBB_0204);

        // 5 rdy_in low freezes the miss
        expect_inst(32'h5555_0001);
        req(32'h0000_5000);
        rdy_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.mem_pc_done_i = 1'b1;
            bus.mem_pc_num_i  = 32'h0000_5000;
            bus.mem_inst_i    = 32'h5555_0001;
            tick();
            check("t5_frozen_busy", {31'd0, bus.if_busy_o}, 32'd1);
        end
        bus.mem_pc_done_i = 1'b0;
        rdy_in = 1'b1;
        tick();
        check("t5_still_miss", {31'd0, bus.if_busy_o}, 32'd1);
        check("t5_no_serve", n_served, n_expected - 1);
        mem_done(32'h0000_5000, 32'h5555_0001);
        wait_served();
        expect_inst(32'h5555_0001);
        req(32'h0000_5000);
        check("t5_hit", {31'd0, bus.if_busy_o}, 32'd0);
        wait_served();

        // 6 counters and reset in the middle of a miss
        rst = 1'b1;
        tick();
        rst = 1'b0;
        miss_fill(32'h0000_1000, 32'h0010_0093);
        expect_inst(32'h0010_0093);
        req(32'h0000_1000);
        expect_inst(32'h0010_0093);
        req(32'h0000_1000);
        wait_served();
`ifdef ICACHE_STAT_EN
        check("t6_hit_cnt", hit_cnt, 32'd2);
        check("t6_miss_cnt", miss_cnt, 32'd1);
`endif
        req(32'h0000_2000);
        check("t6_busy", {31'd0, bus.if_busy_o}, 32'd1);
        tick();
        rst = 1'b1;
        #1;
        check("t6_rst_busy", {31'd0, bus.if_busy_o}, 32'd0);
`ifdef ICACHE_STAT_EN
        check("t6_rst_hit_cnt", hit_cnt, 32'd0);
        check("t6_rst_miss_cnt", miss_cnt, 32'd0);
`endif
        tick();
        rst = 1'b0;
        mem_done(32'h0000_2000, 32'h7777_7777);
        check("t6_late_done", {31'd0, bus.if_busy_o}, 32'd0);
        req(32'h0000_1000);
        check("t6_refetch", {31'd0, bus.if_busy_o}, 32'd1);
        expect_inst(32'h0010_0093);
        mem_done(32'h0000_1000, 32'h0010_0093);
        wait_served();

        tick();
        tick();
        check("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
